// File: rtl/isa_fetch.sv
// Instruction fetch: streams a program from DRAM in credit-limited bursts into a FWFT buffer for the CCU decoder.
// Optional stall-cycle counter (StallCnt) is built when ISA_FETCH_PERF_CNT_EN is defined.
module isa_fetch #(
    parameter int PORT_WIDTH      = 128,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 3,
    parameter int BURST_LEN       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       CfgVld,
    output logic                       CfgRdy,
    input  logic [DRAM_ADDR_WIDTH-1:0] CfgBaseAddr,
    input  logic [ADDR_WIDTH-1:0]      CfgNumWord,
    output logic                       ISAITF_RdReqVld,
    input  logic                       ITFISA_RdReqRdy,
    output logic [DRAM_ADDR_WIDTH-1:0] ISAITF_RdReqAddr,
    output logic [7:0]                 ISAITF_RdReqLen,
    input  logic [PORT_WIDTH-1:0]      ITFISA_RdDat,
    input  logic                       ITFISA_RdDatVld,
    output logic                       ISAITF_RdDatRdy,
    output logic [PORT_WIDTH-1:0]      ITFCCU_ISARdDat,
    output logic                       ITFCCU_ISARdDatVld,
    output logic                       ITFCCU_ISARdDatLast,
    input  logic                       CCUITF_ISARdDatRdy
`ifdef ISA_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                StallCnt
`endif
);

    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam int CW    = FIFO_ADDR_WIDTH + 1;
    localparam int BYTES = PORT_WIDTH / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]                 r_state;
    logic [ADDR_WIDTH-1:0]      r_num_word;
    logic [DRAM_ADDR_WIDTH-1:0] r_req_addr;
    logic [ADDR_WIDTH-1:0]      r_req_cnt;
    logic [ADDR_WIDTH-1:0]      r_out_cnt;
    logic [CW-1:0]              r_outstanding;
    logic [CW-1:0]              r_wr_ptr;
    logic [CW-1:0]              r_rd_ptr;
    logic [PORT_WIDTH-1:0]      r_mem [DEPTH];

    logic                  w_start;
    logic [ADDR_WIDTH-1:0] w_remain;
    logic [7:0]            w_len;
    logic [CW-1:0]         w_count;
    logic                  w_empty;
    logic [CW:0]           w_free;
    logic                  w_credit_ok;
    logic                  w_req_acc;
    logic                  w_req_last;
    logic                  w_wr;
    logic                  w_pop;

    assign CfgRdy   = (r_state == S_IDLE);
    assign w_start  = CfgVld & CfgRdy;
    assign w_remain = r_num_word - r_req_cnt;
    assign w_len    = (w_remain > ADDR_WIDTH'(BURST_LEN)) ? 8'(BURST_LEN) : 8'(w_remain);

    // Credit = free slots minus words already in flight, so every returned word has a slot waiting.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_count == '0);
    assign w_free      = (CW+1)'(DEPTH) - (CW+1)'(w_count) - (CW+1)'(r_outstanding);
    assign w_credit_ok = (32'(w_free) >= 32'(w_len));

    assign ISAITF_RdReqVld  = (r_state == S_FETCH) && w_credit_ok;
    assign ISAITF_RdReqAddr = r_req_addr;
    assign ISAITF_RdReqLen  = w_len;
    assign w_req_acc        = ISAITF_RdReqVld & ITFISA_RdReqRdy;
    assign w_req_last       = w_req_acc && (w_remain <= ADDR_WIDTH'(BURST_LEN));

    assign ISAITF_RdDatRdy = 1'b1;
    assign w_wr            = ITFISA_RdDatVld && (r_state != S_IDLE);

    assign ITFCCU_ISARdDatVld  = !w_empty;
    assign ITFCCU_ISARdDat     = w_empty ? '0 : r_mem[r_rd_ptr[FIFO_ADDR_WIDTH-1:0]];
    assign ITFCCU_ISARdDatLast = !w_empty && (r_out_cnt == r_num_word - ADDR_WIDTH'(1));
    assign w_pop               = !w_empty && CCUITF_ISARdDatRdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_num_word    <= '0;
            r_req_addr    <= '0;
            r_req_cnt     <= '0;
            r_out_cnt     <= '0;
            r_outstanding <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start && CfgNumWord != '0) r_state <= S_FETCH;
                S_FETCH: if (w_req_last) r_state <= S_DRAIN;
                S_DRAIN: if (w_pop && ITFCCU_ISARdDatLast) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_start) begin
                r_num_word <= CfgNumWord;
                r_req_addr <= CfgBaseAddr;
                r_req_cnt  <= '0;
                r_out_cnt  <= '0;
            end else begin
                if (w_req_acc) begin
                    r_req_addr <= r_req_addr + DRAM_ADDR_WIDTH'(w_len) * DRAM_ADDR_WIDTH'(BYTES);
                    r_req_cnt  <= r_req_cnt + ADDR_WIDTH'(w_len);
                end
                if (w_pop) r_out_cnt <= r_out_cnt + ADDR_WIDTH'(1);
            end

            r_outstanding <= r_outstanding + (w_req_acc ? CW'(w_len) : CW'(0)) - (w_wr ? CW'(1) : CW'(0));
            if (w_wr)  r_wr_ptr <= r_wr_ptr + CW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + CW'(1);
        end
    end

    // NOTE: the buffer storage has no reset; the pointers define validity and the output is gated when empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= ITFISA_RdDat;
    end

`ifdef ISA_FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_stall_cnt <= '0;
        end else if (r_state != S_IDLE && w_empty && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign StallCnt = r_stall_cnt;
`endif

endmodule

// File: doc/isa_fetch.md
ISA_FETCH -- requirements
Module: isa_fetch

Interface
REQ-001 SHALL have parameter PORT_WIDTH, default 128, instruction word width in bits (16 bytes).
REQ-002 SHALL have parameter DRAM_ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, program length field width, counted in words.
REQ-004 SHALL have parameter FIFO_ADDR_WIDTH, default 3, giving a buffer depth of 2^FIFO_ADDR_WIDTH words.
REQ-005 SHALL have parameter BURST_LEN, default 4, maximum words per DRAM read request, not larger than the buffer depth.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port CfgVld, input, 1 bit: program fetch start request.
REQ-009 SHALL have port CfgRdy, output, 1 bit: block is idle and accepts a start.
REQ-010 SHALL have port CfgBaseAddr, input, DRAM_ADDR_WIDTH bits: program byte base address, word aligned.
REQ-011 SHALL have port CfgNumWord, input, ADDR_WIDTH bits: program length in words.
REQ-012 SHALL have port ISAITF_RdReqVld, output, 1 bit: DRAM read request valid.
REQ-013 SHALL have port ITFISA_RdReqRdy, input, 1 bit: DRAM read request accepted.
REQ-014 SHALL have port ISAITF_RdReqAddr, output, DRAM_ADDR_WIDTH bits: request byte address.
REQ-015 SHALL have port ISAITF_RdReqLen, output, 8 bits: request length in words.
REQ-016 SHALL have port ITFISA_RdDat, input, PORT_WIDTH bits: returned instruction word.
REQ-017 SHALL have port ITFISA_RdDatVld, input, 1 bit: returned word valid.
REQ-018 SHALL have port ISAITF_RdDatRdy, output, 1 bit: returned word accepted.
REQ-019 SHALL have port ITFCCU_ISARdDat, output, PORT_WIDTH bits: word to the CCU decoder.
REQ-020 SHALL have port ITFCCU_ISARdDatVld, output, 1 bit: word valid.
REQ-021 SHALL have port ITFCCU_ISARdDatLast, output, 1 bit: final word of the program.
REQ-022 SHALL have port CCUITF_ISARdDatRdy, input, 1 bit: decoder accepts the word.

Function
REQ-023 SHALL implement states IDLE, FETCH and DRAIN.
- IDLE to FETCH: on a CfgVld & CfgRdy handshake with CfgNumWord > 0.
- FETCH to DRAIN: when the request that covers the last word is accepted.
- DRAIN to IDLE: on the output handshake of the word flagged Last.
REQ-024 SHALL hold CfgRdy = 1 only in IDLE; a handshake with CfgNumWord = 0 stays in IDLE and produces no request and no output.
REQ-025 SHALL latch CfgBaseAddr and CfgNumWord on the handshake, and assert the first request on the following cycle if credit allows.
REQ-026 SHALL set ISAITF_RdReqLen = min(BURST_LEN, remaining words to request).
REQ-027 SHALL set ISAITF_RdReqAddr = base + (words already requested) × PORT_WIDTH/8, with wrap-around modulo 2^DRAM_ADDR_WIDTH.
REQ-028 SHALL assert a request only when the free buffer slots minus the words outstanding (requested but not yet returned) are at least RdReqLen.
REQ-029 SHALL hold address and length stable while RdReqVld is high and RdReqRdy is low.
REQ-030 SHALL drive ISAITF_RdDatRdy = 1 at all times; the credit scheme of REQ-028 guarantees the buffer never overflows.
REQ-031 SHALL write returned words in FETCH/DRAIN into a first-word-fall-through buffer; a word accepted at cycle t SHALL be visible on ITFCCU_ISARdDat at t+1.
REQ-032 SHALL drop returned words that arrive in IDLE, i.e. stale data after a reset.
REQ-033 SHALL drive ITFCCU_ISARdDatVld = buffer not empty, and pop the buffer on Vld & Rdy.
REQ-034 SHALL assert ITFCCU_ISARdDatLast together with Vld only for output word index CfgNumWord-1.
REQ-035 SHALL allow a write and a pop in the same cycle when the buffer is full, and SHALL keep the occupancy unchanged in that case.
REQ-036 SHALL update the outstanding count by +RdReqLen on request acceptance and -1 on each returned word; both events in one cycle SHALL apply both changes.

Reset
REQ-037 SHALL, while rst = 1 at a clock edge, enter IDLE and clear the buffer, pointers, outstanding count and the requested/delivered counters.
REQ-038 SHALL, during reset, drive CfgRdy = 1 after the first edge and all other outputs to 0 (RdDatRdy stays 1).
REQ-039 SHALL abort a program when reset is asserted mid-program, with no further words emitted.

Configuration
REQ-040 SHALL, with macro ISA_FETCH_PERF_CNT_EN defined, add output port StallCnt (32 bits).
- It counts cycles in FETCH/DRAIN with ITFCCU_ISARdDatVld = 0.
- It is cleared by reset and by each start handshake, and saturates at all-ones.
REQ-041 SHALL, without ISA_FETCH_PERF_CNT_EN, contain neither the StallCnt port nor its counter.

Verification
REQ-042 SHALL cover: base 0x1000, NumWord 10, DRAM always ready, 3-cycle return latency.
- Requests (0x1000,4), (0x1040,4), (0x1080,2).
- 10 words out in order; Last on the 10th only.
REQ-043 SHALL cover: NumWord 0.
- CfgRdy is high again the next cycle; no RdReqVld, no ITFCCU_ISARdDatVld.
REQ-044 SHALL cover: CCUITF_ISARdDatRdy held 0 with NumWord 20.
- At most 8 words are requested before stalling; no overflow.
- Releasing Rdy completes all 20 words.
REQ-045 SHALL cover: base 0xFFFFFFF0, NumWord 2.
- Single request (0xFFFFFFF0,2) is issued.
- With BURST_LEN 1, the second request address is 0x00000000.
REQ-046 SHALL cover: rst pulsed mid-program with 3 returns outstanding.
- Late returns are dropped; no output Vld.
- A new start is then accepted normally.
REQ-047 SHALL cover, with ISA_FETCH_PERF_CNT_EN: a 5-cycle output gap before the first word.
- StallCnt = 5 plus the return latency cycles.
